// File: rtl/mont_mul_ctrl.sv
// Bit-serial Montgomery multiplier (a*b*2^-N mod m) sequencing the shared 514-bit multi-cycle adder.
// Latency 5*(N+popcount(a))+6 cycles start->done; start is ignored unless idle, adder ops run back to back.
module mont_mul_ctrl #(
    parameter int N = 512
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic [N-1:0]   in_m,
    output logic [N-1:0]   result,
    output logic           done,
    output logic           busy,
    output logic           adder_start,
    output logic           adder_subtract,
    output logic           adder_shift,
    output logic [513:0]   adder_in_a,
    output logic [513:0]   adder_in_b,
    input  logic [514:0]   adder_result,
    input  logic           adder_done
);
    localparam int CW = 514;
    localparam int IW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OP   = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [1:0] OP_B   = 2'd0;
    localparam logic [1:0] OP_M   = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    r_op;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_m;
    logic [N-1:0]  r_result;
    logic [CW-1:0] r_c;
    logic [IW-1:0] r_i;
    logic          r_done;
    logic          r_busy;

    logic          w_active;
    logic          w_last;
    logic [CW-1:0] w_sub_c;
    logic [CW-1:0] w_b_ext;
    logic [CW-1:0] w_m_ext;

    assign w_active = (r_state == S_OP) || (r_state == S_WAIT);
    assign w_last   = (r_i == IW'(N - 1));
    // adder_result[514] set means no borrow, i.e. C >= m.
    assign w_sub_c  = adder_result[CW] ? adder_result[CW-1:0] : r_c;
    assign w_b_ext  = {{(CW-N){1'b0}}, r_b};
    assign w_m_ext  = {{(CW-N){1'b0}}, r_m};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_op     <= OP_M;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_result <= '0;
            r_c      <= '0;
            r_i      <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // r_a holds the not-yet-consumed bits a[N-1:1]; bit 0 picks the first op.
                        r_a     <= in_a >> 1;
                        r_b     <= in_b;
                        r_m     <= in_m;
                        r_c     <= '0;
                        r_i     <= '0;
                        r_busy  <= 1'b1;
                        r_op    <= in_a[0] ? OP_B : OP_M;
                        r_state <= S_OP;
                    end
                end
                S_OP: r_state <= S_WAIT;
                S_WAIT: begin
                    if (adder_done) begin
                        case (r_op)
                            OP_B: begin
                                r_c     <= adder_result[CW-1:0];
                                r_op    <= OP_M;
                                r_state <= S_OP;
                            end
                            OP_M: begin
                                r_c     <= adder_result[CW-1:0];
                                r_a     <= r_a >> 1;
                                r_i     <= r_i + IW'(1);
                                r_op    <= w_last ? OP_SUB : (r_a[0] ? OP_B : OP_M);
                                r_state <= S_OP;
                            end
                            default: begin
                                r_c      <= w_sub_c;
                                r_result <= w_sub_c[N-1:0];
                                r_done   <= 1'b1;
                                r_state  <= S_FIN;
                            end
                        endcase
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operands depend only on registers that change at adder_done, so they stay put for the whole op.
    always_comb begin
        adder_in_b = '0;
        if (w_active) begin
            case (r_op)
                OP_B:    adder_in_b = w_b_ext;
                OP_M:    adder_in_b = r_c[0] ? w_m_ext : '0;
                default: adder_in_b = w_m_ext;
            endcase
        end
    end

    assign adder_in_a     = w_active ? r_c : '0;
    assign adder_start    = (r_state == S_OP);
    assign adder_subtract = w_active && (r_op == OP_SUB);
    assign adder_shift    = (r_state == S_WAIT) && adder_done && (r_op == OP_M);
    assign result         = r_result;
    assign done           = r_done;
    assign busy           = r_busy;
endmodule

// File: tb/tb_mont_mul_ctrl.sv
// Bench for mont_mul_ctrl (N=8) with a behavioural 4-cycle adder and a protocol monitor.
module tb_mont_mul_ctrl;
    localparam int N   = 8;
    localparam int W   = 514;
    localparam int LIM = 200;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   in_a = '0;
    logic [N-1:0]   in_b = '0;
    logic [N-1:0]   in_m = '0;
    logic [N-1:0]   result;
    logic           done;
    logic           busy;
    logic           adder_start;
    logic           adder_subtract;
    logic           adder_shift;
    logic [W-1:0]   adder_in_a;
    logic [W-1:0]   adder_in_b;
    logic [W:0]     adder_result;
    logic           adder_done;

    mont_mul_ctrl #(.N(N)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .result(result), .done(done), .busy(busy),
        .adder_start(adder_start), .adder_subtract(adder_subtract), .adder_shift(adder_shift),
        .adder_in_a(adder_in_a), .adder_in_b(adder_in_b),
        .adder_result(adder_result), .adder_done(adder_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder model: done exactly 4 cycles after the start cycle, result from operands captured at start.
    logic         ad_busy = 1'b0;
    logic [2:0]   ad_cnt = '0;
    logic [W-1:0] cap_a = '0;
    logic [W-1:0] cap_b = '0;
    logic         cap_sub = 1'b0;
    logic [W:0]   ad_sum;

    always @(posedge clk) begin
        if (!resetn) begin
            ad_busy <= 1'b0;
            ad_cnt  <= '0;
        end else if (!ad_busy) begin
            if (adder_start) begin
                ad_busy <= 1'b1;
                ad_cnt  <= 3'd1;
                cap_a   <= adder_in_a;
                cap_b   <= adder_in_b;
                cap_sub <= adder_subtract;
            end
        end else if (ad_cnt == 3'd4) begin
            ad_busy <= 1'b0;
            ad_cnt  <= '0;
        end else begin
            ad_cnt <= ad_cnt + 3'd1;
        end
    end

    assign adder_done = ad_busy && (ad_cnt == 3'd4);

    always_comb begin
        ad_sum = '0;
        if (cap_sub) ad_sum = {1'b0, cap_a} + {1'b0, ~cap_b} + 515'd1;
        else         ad_sum = {1'b0, cap_a} + {1'b0, cap_b};
        adder_result = adder_shift ? (ad_sum >> 1) : ad_sum;
    end

    // Protocol monitor: cumulative counters, read as deltas by the test sequence.
    int   n_start = 0, n_bop = 0, n_mop = 0, n_sop = 0, prot_err = 0, gap_err = 0;
    int   prev_start = -1;
    logic prev_sub = 1'b0;
    logic last_ge = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_start = -1;
        end else begin
            if (adder_start) begin
                if (ad_busy) prot_err++;
                if (prev_start >= 0 && !prev_sub && (cyc - prev_start) != 5) gap_err++;
                prev_start = cyc;
                n_start++;
            end
            if (ad_busy && (adder_in_a !== cap_a || adder_in_b !== cap_b || adder_subtract !== cap_sub))
                prot_err++;
            if (adder_shift && !adder_done) prot_err++;
            if (adder_done) begin
                if (adder_subtract) begin
                    n_sop++;
                    last_ge  = adder_result[W];
                    prev_sub = 1'b1;
                    if (adder_shift) prot_err++;
                end else begin
                    if (adder_shift) n_mop++;
                    else             n_bop++;
                    prev_sub = 1'b0;
                    if (adder_result[W]) prot_err++;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int rep_at, output int lat, output int busy_drop);
        lat = -1;
        busy_drop = 0;
        for (int k = 1; k <= LIM; k++) begin
            @(negedge clk);
            start = (k == rep_at);
            if (k == rep_at) in_a = 8'h01;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_drop++;
        end
        start = 1'b0;
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input int rep_at, output int lat, output int busy_drop);
        @(negedge clk);
        in_a = a; in_b = b; in_m = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_a = ~a; in_b = ~b; in_m = 8'h55;
        wait_done(rep_at, lat, busy_drop);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        int         rep_at;
        int         exp_res;
        int         exp_lat;
        int         exp_pop;
        logic       exp_ge;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, bd, s0, b0, m0, p0, g0, e0, r_keep;

        // a*b*2^-8 mod m; 2^-8 = 3 (mod 13), 4 (mod 11); latency 5*(8+popcount(a))+6.
        vecs[0] = '{a: 8'd1,   b: 8'd1,  m: 8'd13, rep_at: 0,  exp_res: 3, exp_lat: 51, exp_pop: 1, exp_ge: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd7,  m: 8'd13, rep_at: 0,  exp_res: 1, exp_lat: 56, exp_pop: 2, exp_ge: 1'b0};
        vecs[2] = '{a: 8'd0,   b: 8'd12, m: 8'd13, rep_at: 0,  exp_res: 0, exp_lat: 46, exp_pop: 0, exp_ge: 1'b0};
        vecs[3] = '{a: 8'd12,  b: 8'd12, m: 8'd13, rep_at: 0,  exp_res: 3, exp_lat: 56, exp_pop: 2, exp_ge: 1'b0};
        vecs[4] = '{a: 8'd192, b: 8'd11, m: 8'd13, rep_at: 0,  exp_res: 5, exp_lat: 56, exp_pop: 2, exp_ge: 1'b1};
        vecs[5] = '{a: 8'd255, b: 8'd12, m: 8'd13, rep_at: 0,  exp_res: 2, exp_lat: 86, exp_pop: 8, exp_ge: 1'b1};
        vecs[6] = '{a: 8'd3,   b: 8'd5,  m: 8'd11, rep_at: 10, exp_res: 5, exp_lat: 56, exp_pop: 2, exp_ge: 1'b0};

        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_adder_ctl", {adder_start, adder_subtract, adder_shift}, 0);
        check("rst_adder_in", {|adder_in_a, |adder_in_b}, 0);
        resetn = 1'b1;

        s0 = n_start;
        bd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy || result != 0) bd++;
        end
        check("idle_outputs", bd, 0);
        check("idle_no_adder_start", n_start - s0, 0);

        for (int v = 0; v < 7; v++) begin
            s0 = n_start; b0 = n_bop; m0 = n_mop; p0 = n_sop; g0 = gap_err; e0 = prot_err;
            run(vecs[v].a, vecs[v].b, vecs[v].m, vecs[v].rep_at, lat, bd);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_result", v), result, vecs[v].exp_res);
            check($sformatf("v%0d_busy_held", v), bd, 0);
            check($sformatf("v%0d_adder_starts", v), n_start - s0, vecs[v].exp_pop + N + 1);
            check($sformatf("v%0d_b_steps", v), n_bop - b0, vecs[v].exp_pop);
            check($sformatf("v%0d_m_steps", v), n_mop - m0, N);
            check($sformatf("v%0d_sub_steps", v), n_sop - p0, 1);
            check($sformatf("v%0d_sub_branch", v), last_ge, vecs[v].exp_ge);
            check($sformatf("v%0d_gaps", v), gap_err - g0, 0);
            check($sformatf("v%0d_protocol", v), prot_err - e0, 0);
            r_keep = result;
            @(negedge clk);
            check($sformatf("v%0d_busy_after", v), {busy, done}, 0);
            check($sformatf("v%0d_result_held", v), result, r_keep);
        end

        // start held across FIN and the following IDLE cycle: only the IDLE sample counts.
        run(8'd1, 8'd1, 8'd13, 0, lat, bd);
        check("fin_first_result", result, 3);
        in_a = 8'd5; in_b = 8'd7; in_m = 8'd13; start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_a = 8'd0;
        wait_done(0, lat, bd);
        check("fin_restart_latency", lat, 56);
        check("fin_restart_result", result, 1);

        // Reset mid-operation aborts without done; a fresh start then completes.
        @(negedge clk);
        in_a = 8'd5; in_b = 8'd7; in_m = 8'd13; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k < 20; k++) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        resetn = 1'b1;
        bd = 0;
        repeat (70) begin
            @(negedge clk);
            if (done || busy) bd++;
        end
        check("abort_quiet", bd, 0);
        e0 = prot_err;
        run(8'd192, 8'd11, 8'd13, 0, lat, bd);
        check("post_abort_latency", lat, 56);
        check("post_abort_result", result, 5);
        check("post_abort_protocol", prot_err - e0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
